mu0_cpu: RTL and testbench
==========================

// Module: mu0_cpu
// PURPOSE
//   16-bit MU0 accumulator processor core: 12-bit word address space, 8 instructions.
//   Two-state fetch/execute sequencer; talks to a separate word-wide memory over Address/Rd/Wr/Data.
//   Top-level CPU of the virtual_cpu design; Halted flags program completion to the system/bench.
// PARAMETERS
//   RESET_PC  12'h000  PC value loaded on reset (first fetch address)
// PORTS
//   Clk       in   1   system clock; all state updates on rising edge
//   Reset     in   1   asynchronous, active-low reset
//   Data_in   in   16  read data from memory (combinational read of Address when Rd=1)
//   Rd        out  1   memory read strobe
//   Wr        out  1   memory write strobe (memory writes Data_out at the next rising Clk edge)
//   Address   out  12  memory word address
//   Data_out  out  16  write data (= ACC)
//   Halted    out  1   high once STP has executed; held until reset
// BEHAVIOUR
//   Registers: ACC[15:0], PC[11:0], IR[15:0], state {FETCH, EXEC, HALT}, all updated only at posedge Clk.
//   Reset low (async): PC=RESET_PC, ACC=0, IR=0, state=FETCH, Halted=0; held while Reset stays low.
//   Instruction: IR[15:12]=opcode F, IR[11:0]=operand address S.
//   FETCH: Address=PC, Rd=1, Wr=0; at edge IR<=Data_in, PC<=PC+1 (mod 4096, 12'hFFF wraps to 0), ->EXEC.
//   EXEC: Address=IR[11:0]; at edge ->FETCH unless STP. By opcode:
//     0 LDA: Rd=1; ACC<=mem[S]
//     1 STA: Wr=1; Data_out=ACC; mem[S]<=ACC at the edge
//     2 ADD: Rd=1; ACC<=ACC+mem[S] (mod 2^16, no flags)
//     3 SUB: Rd=1; ACC<=ACC-mem[S] (mod 2^16)
//     4 JMP: PC<=S
//     5 JGE: PC<=S if ACC[15]==0 (signed ACC>=0), else PC unchanged
//     6 JNE: PC<=S if ACC!=0
//     7 STP: ->HALT; PC, ACC unchanged
//     8-F: no operation; Rd=Wr=0; ->FETCH
//   Rd and Wr are never high together; in EXEC of JMP/JGE/JNE/STP both are 0.
//   HALT: Rd=Wr=0, Address=PC, Halted=1 (registered: rises at the edge that ends STP's EXEC), stays
//     until Reset asserted; no register changes while halted.
//   Data_out always drives ACC; Address/Rd/Wr decoded combinationally from state and IR.
//   Every instruction except STP takes exactly 2 cycles (fetch + execute).
//   Reset asserted mid-instruction: immediate return to reset state; any in-progress store is
//     dropped (Wr forced 0 while Reset low).
// TESTING
//   Reset low 100 ns then high, mem[0]=0x0000 -> first fetch Address=0x000, Rd=1; ACC=0, Halted=0.
//   mem: 0:LDA 0x10, 1:ADD 0x11, 2:STA 0x12, 3:STP; [0x10]=5,[0x11]=7
//     -> mem[0x12]=0x000C after 8 cycles, Halted=1, Rd=Wr=0 thereafter.
//   LDA [0x10]=3; SUB [0x11]=5 -> ACC=0xFFFE; JGE 0x20 not taken (next fetch 0x003);
//     then JMP 0x20 -> next fetch Address=0x020.
//   Countdown: ACC=3, loop SUB one / JNE loop -> loop taken twice, falls through when ACC=0; STP.
//   PC wrap: JMP 0xFFF with mem[0xFFF]=0x8000 (NOP) -> next fetch Address=0x000.
//   Reset asserted during STA execute cycle -> no write to memory, PC=0, ACC=0, Halted=0.

Source files
------------

// File: rtl/mu0_cpu.sv
// MU0 16-bit accumulator processor: 12-bit word address space, 8 instructions,
// two-state fetch/execute sequencer with a terminal HALT state.
module mu0_cpu #(
    parameter logic [11:0] RESET_PC = 12'h000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Data_in,
    output logic        Rd,
    output logic        Wr,
    output logic [11:0] Address,
    output logic [15:0] Data_out,
    output logic        Halted
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    state_t      state_r;
    logic [15:0] acc_r;
    logic [11:0] pc_r;
    logic [15:0] ir_r;
    logic        halted_r;

    logic [3:0]  opcode_s;
    logic [11:0] operand_s;
    logic        rd_s;
    logic        wr_s;
    logic [11:0] addr_s;

    assign opcode_s  = ir_r[15:12];
    assign operand_s = ir_r[11:0];

    // Sequencer and architectural register updates.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r  <= ST_FETCH;
            acc_r    <= 16'h0000;
            pc_r     <= RESET_PC;
            ir_r     <= 16'h0000;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    ir_r    <= Data_in;
                    pc_r    <= pc_r + 12'd1;
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    state_r <= ST_FETCH;
                    case (opcode_s)
                        OP_LDA:  acc_r <= Data_in;
                        OP_ADD:  acc_r <= acc_r + Data_in;
                        OP_SUB:  acc_r <= acc_r - Data_in;
                        OP_JMP:  pc_r  <= operand_s;
                        OP_JGE: begin
                            if (acc_r[15] == 1'b0) begin
                                pc_r <= operand_s;
                            end
                        end
                        OP_JNE: begin
                            if (acc_r != 16'h0000) begin
                                pc_r <= operand_s;
                            end
                        end
                        OP_STP: begin
                            state_r  <= ST_HALT;
                            halted_r <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ST_HALT: begin
                    state_r  <= ST_HALT;
                    halted_r <= 1'b1;
                end
                default: state_r <= ST_FETCH;
            endcase
        end
    end

    // Memory bus decode from the current state and instruction.
    always_comb begin
        rd_s   = 1'b0;
        wr_s   = 1'b0;
        addr_s = pc_r;
        case (state_r)
            ST_FETCH: rd_s = 1'b1;
            ST_EXEC: begin
                addr_s = operand_s;
                case (opcode_s)
                    OP_LDA, OP_ADD, OP_SUB: rd_s = 1'b1;
                    OP_STA:                 wr_s = 1'b1;
                    default: begin
                        rd_s = 1'b0;
                        wr_s = 1'b0;
                    end
                endcase
            end
            ST_HALT: begin
                rd_s = 1'b0;
                wr_s = 1'b0;
            end
            default: addr_s = pc_r;
        endcase
    end

    // A store in flight is dropped the moment reset is asserted.
    assign Rd       = rd_s;
    assign Wr       = wr_s & Reset;
    assign Address  = addr_s;
    assign Data_out = acc_r;
    assign Halted   = halted_r;

endmodule

// File: tb/tb_mu0_cpu.sv
// Self-checking bench for mu0_cpu: bench-side memory, an instruction-level
// reference model compared every cycle, and hand-computed spot checks.
module tb_mu0_cpu;

    logic        Clk;
    logic        Reset;
    logic [15:0] Data_in;
    logic        Rd;
    logic        Wr;
    logic [11:0] Address;
    logic [15:0] Data_out;
    logic        Halted;

    logic [15:0] mem   [0:4095];
    logic [15:0] m_mem [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    mu0_cpu #(.RESET_PC(12'h000)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Data_in  (Data_in),
        .Rd       (Rd),
        .Wr       (Wr),
        .Address  (Address),
        .Data_out (Data_out),
        .Halted   (Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign Data_in = mem[Address];

    // Memory write port: stores land at the rising edge.
    initial begin
        forever begin
            @(posedge Clk);
            if (Wr) mem[Address] <= Data_out;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction-level reference model, stepped once per cycle.
    logic [11:0] m_pc;
    logic [15:0] m_acc;
    logic [15:0] m_ir;
    logic        m_halted;
    logic        m_exec;

    initial begin
        logic [3:0]  op;
        logic [11:0] s;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                m_pc = 12'h000; m_acc = 16'h0000; m_ir = 16'h0000;
                m_halted = 1'b0; m_exec = 1'b0;
            end else if (m_halted) begin
                chk("halt_addr", 32'(Address), 32'(m_pc));
                chk("halt_rd", 32'(Rd), 32'd0);
                chk("halt_wr", 32'(Wr), 32'd0);
                chk("halt_flag", 32'(Halted), 32'd1);
                chk("halt_dout", 32'(Data_out), 32'(m_acc));
            end else if (!m_exec) begin
                chk("fetch_addr", 32'(Address), 32'(m_pc));
                chk("fetch_rd", 32'(Rd), 32'd1);
                chk("fetch_wr", 32'(Wr), 32'd0);
                chk("fetch_halted", 32'(Halted), 32'd0);
                chk("fetch_dout", 32'(Data_out), 32'(m_acc));
                m_ir   = m_mem[m_pc];
                m_pc   = m_pc + 12'd1;
                m_exec = 1'b1;
            end else begin
                op = m_ir[15:12];
                s  = m_ir[11:0];
                chk("exec_addr", 32'(Address), 32'(s));
                chk("exec_rd", 32'(Rd), (op == 4'h0 || op == 4'h2 || op == 4'h3) ? 32'd1 : 32'd0);
                chk("exec_wr", 32'(Wr), (op == 4'h1) ? 32'd1 : 32'd0);
                chk("exec_halted", 32'(Halted), 32'd0);
                chk("exec_dout", 32'(Data_out), 32'(m_acc));
                case (op)
                    4'h0: m_acc = m_mem[s];
                    4'h1: m_mem[s] = m_acc;
                    4'h2: m_acc = m_acc + m_mem[s];
                    4'h3: m_acc = m_acc - m_mem[s];
                    4'h4: m_pc = s;
                    4'h5: if ($signed(m_acc) >= 0) m_pc = s;
                    4'h6: if (m_acc != 16'h0000) m_pc = s;
                    4'h7: m_halted = 1'b1;
                    default: ;
                endcase
                m_exec = 1'b0;
            end
        end
    end

    task automatic begin_prog();
        Reset = 1'b0;
        @(negedge Clk);
        for (int i = 0; i < 4096; i++) begin
            mem[i]   = 16'h0000;
            m_mem[i] = 16'h0000;
        end
    endtask

    task automatic load(input logic [11:0] a, input logic [15:0] d);
        mem[a]   = d;
        m_mem[a] = d;
    endtask

    // Release reset just after a rising edge, then stop at cycle 0's falling edge.
    task automatic release_reset(input int hold);
        repeat (hold) @(posedge Clk);
        #2 Reset = 1'b1;
        @(negedge Clk);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic mem_vs_model(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 4096; i++) if (mem[i] !== m_mem[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    initial begin
        Reset = 1'b0;

        // Program 1: 5 + 7 stored to 0x12, then stop.
        begin_prog();
        load(12'h000, 16'h0010); load(12'h001, 16'h2011);
        load(12'h002, 16'h1012); load(12'h003, 16'h7000);
        load(12'h010, 16'h0005); load(12'h011, 16'h0007);
        #100;
        release_reset(1);
        chk("p1_reset_addr", 32'(Address), 32'h000);
        chk("p1_reset_rd", 32'(Rd), 32'd1);
        chk("p1_reset_acc", 32'(Data_out), 32'h0000);
        chk("p1_reset_halted", 32'(Halted), 32'd0);
        cyc(7);
        chk("p1_not_yet_halted", 32'(Halted), 32'd0);
        cyc(1);
        chk("p1_halted", 32'(Halted), 32'd1);
        chk("p1_mem12", 32'(mem[12'h012]), 32'h000C);
        chk("p1_acc", 32'(Data_out), 32'h000C);
        chk("p1_halt_addr", 32'(Address), 32'h004);
        chk("p1_halt_rdwr", 32'({Rd, Wr}), 32'd0);
        cyc(3);
        chk("p1_still_halted", 32'(Halted), 32'd1);
        mem_vs_model("p1_mem_model");

        // Program 2: 3 - 5 is negative, JGE not taken, JMP taken.
        begin_prog();
        load(12'h000, 16'h0010); load(12'h001, 16'h3011);
        load(12'h002, 16'h5020); load(12'h003, 16'h4020);
        load(12'h020, 16'h7000);
        load(12'h010, 16'h0003); load(12'h011, 16'h0005);
        release_reset(2);
        cyc(6);
        chk("p2_jge_fallthru", 32'(Address), 32'h003);
        chk("p2_jge_rd", 32'(Rd), 32'd1);
        chk("p2_acc", 32'(Data_out), 32'hFFFE);
        cyc(2);
        chk("p2_jmp_target", 32'(Address), 32'h020);
        chk("p2_jmp_rd", 32'(Rd), 32'd1);
        cyc(2);
        chk("p2_halted", 32'(Halted), 32'd1);
        chk("p2_halt_addr", 32'(Address), 32'h021);

        // Program 3: countdown loop from 3 with JNE, result stored over a marker.
        begin_prog();
        load(12'h000, 16'h0010); load(12'h001, 16'h3011);
        load(12'h002, 16'h6001); load(12'h003, 16'h1012);
        load(12'h004, 16'h7000);
        load(12'h010, 16'h0003); load(12'h011, 16'h0001);
        load(12'h012, 16'hDEAD);
        release_reset(2);
        cyc(17);
        chk("p3_not_yet_halted", 32'(Halted), 32'd0);
        cyc(1);
        chk("p3_halted", 32'(Halted), 32'd1);
        chk("p3_mem12", 32'(mem[12'h012]), 32'h0000);
        chk("p3_halt_addr", 32'(Address), 32'h005);
        mem_vs_model("p3_mem_model");

        // Program 4: PC wraps from 0xFFF to 0x000 past a NOP.
        begin_prog();
        load(12'h000, 16'h4FFF); load(12'hFFF, 16'h8000);
        release_reset(2);
        cyc(2);
        chk("p4_fetch_fff", 32'(Address), 32'hFFF);
        chk("p4_fetch_fff_rd", 32'(Rd), 32'd1);
        cyc(1);
        chk("p4_nop_rdwr", 32'({Rd, Wr}), 32'd0);
        cyc(1);
        chk("p4_wrap_addr", 32'(Address), 32'h000);
        chk("p4_wrap_rd", 32'(Rd), 32'd1);

        // Program 5: reset lands in the STA execute cycle; the store is dropped.
        begin_prog();
        load(12'h000, 16'h0010); load(12'h001, 16'h1012);
        load(12'h010, 16'h0005);
        release_reset(2);
        cyc(3);
        chk("p5_sta_wr", 32'(Wr), 32'd1);
        chk("p5_sta_addr", 32'(Address), 32'h012);
        chk("p5_sta_dout", 32'(Data_out), 32'h0005);
        #2 Reset = 1'b0;
        #1;
        chk("p5_rst_wr", 32'(Wr), 32'd0);
        chk("p5_rst_addr", 32'(Address), 32'h000);
        chk("p5_rst_acc", 32'(Data_out), 32'h0000);
        chk("p5_rst_halted", 32'(Halted), 32'd0);
        @(posedge Clk);
        #1;
        chk("p5_no_store", 32'(mem[12'h012]), 32'h0000);
        cyc(2);
        chk("p5_held_addr", 32'(Address), 32'h000);
        chk("p5_held_halted", 32'(Halted), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
